// File: rtl/debounce_pulse.sv
// ============================================================================
// debounce_pulse
// ----------------------------------------------------------------------------
// Conditions a raw, asynchronous, possibly bouncing input into a clean
// debounced level and a single-cycle pulse per accepted transition. The pulse
// is meant to drive the increment-enable of the modulo event counter.
//
// Processing chain:
//   raw_in -> SYNC_STAGES-deep synchronizer -> sync_out
//   sync_out -> 4-state qualification FSM (LOW, CHECK_HIGH, HIGH, CHECK_LOW)
//   A new level is accepted once sync_out has differed from the current
//   level for STABLE_CYCLES consecutive samples. Shorter excursions are
//   aborted and counted in a saturating 8-bit glitch counter.
//
// Parameters:
//   SYNC_STAGES   synchronizer depth (>= 2)
//   STABLE_CYCLES consecutive differing samples needed to accept (>= 1)
//   EDGE_MODE     0 = pulse on rise, 1 = pulse on fall, 2 = pulse on both
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   raw_in      raw asynchronous input
//   clr_glitch  synchronous clear of glitch_cnt (wins over an increment)
//   level       debounced level (registered)
//   pulse       one-cycle pulse per selected accepted transition (registered)
//   busy        high while a candidate transition is being qualified
//   glitch_cnt  saturating count of aborted qualifications
// ============================================================================
module debounce_pulse #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int EDGE_MODE     = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw_in,
    input  logic       clr_glitch,
    output logic       level,
    output logic       pulse,
    output logic       busy,
    output logic [7:0] glitch_cnt
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // With a one-sample qualification window the CHECK states are skipped.
    localparam bit SINGLE_SAMPLE = (STABLE_CYCLES == 1);
    localparam bit PULSE_ON_RISE = (EDGE_MODE != 1);
    localparam bit PULSE_ON_FALL = (EDGE_MODE != 0);

    typedef enum logic [1:0] {
        ST_LOW        = 2'd0,
        ST_CHECK_HIGH = 2'd1,
        ST_HIGH       = 2'd2,
        ST_CHECK_LOW  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_out;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   busy_q, busy_d;
    logic [7:0]             glitch_q, glitch_d;

    logic                   rise_accept;
    logic                   fall_accept;
    logic                   abort_qual;

    // Synchronizer shift chain; raw_in enters at bit 0 and nothing else
    // looks at raw_in directly.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Qualification FSM next-state. count holds the number of consecutive
    // samples seen that differ from the current level; reaching
    // STABLE_CYCLES-1 already counted plus the current one accepts.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rise_accept = 1'b0;
        fall_accept = 1'b0;
        abort_qual  = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (sync_out) begin
                    if (SINGLE_SAMPLE) begin
                        state_d     = ST_HIGH;
                        rise_accept = 1'b1;
                    end else begin
                        state_d = ST_CHECK_HIGH;
                        count_d = CNT_ONE;
                    end
                end
            end
            ST_CHECK_HIGH: begin
                if (!sync_out) begin
                    state_d    = ST_LOW;
                    count_d    = '0;
                    abort_qual = 1'b1;
                end else if (count_q == CNT_LAST) begin
                    state_d     = ST_HIGH;
                    count_d     = '0;
                    rise_accept = 1'b1;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!sync_out) begin
                    if (SINGLE_SAMPLE) begin
                        state_d     = ST_LOW;
                        fall_accept = 1'b1;
                    end else begin
                        state_d = ST_CHECK_LOW;
                        count_d = CNT_ONE;
                    end
                end
            end
            ST_CHECK_LOW: begin
                if (sync_out) begin
                    state_d    = ST_HIGH;
                    count_d    = '0;
                    abort_qual = 1'b1;
                end else if (count_q == CNT_LAST) begin
                    state_d     = ST_LOW;
                    count_d     = '0;
                    fall_accept = 1'b1;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                count_d = '0;
            end
        endcase
    end

    // Registered outputs derived from the FSM decision. The pulse is gated
    // by its own previous value so it can never stay high two cycles in a
    // row, which otherwise could happen with a one-sample window and
    // EDGE_MODE=2 when a rise is immediately followed by a fall.
    always_comb begin
        level_d = level_q;
        if (rise_accept) begin
            level_d = 1'b1;
        end else if (fall_accept) begin
            level_d = 1'b0;
        end

        pulse_d = ((rise_accept && PULSE_ON_RISE) ||
                   (fall_accept && PULSE_ON_FALL)) && !pulse_q;

        busy_d = (state_d == ST_CHECK_HIGH) || (state_d == ST_CHECK_LOW);

        glitch_d = glitch_q;
        if (clr_glitch) begin
            glitch_d = 8'd0;
        end else if (abort_qual && (glitch_q != 8'hFF)) begin
            glitch_d = glitch_q + 8'd1;
        end
    end

    // All state and outputs in one register bank with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            state_q  <= ST_LOW;
            count_q  <= '0;
            level_q  <= 1'b0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
            glitch_q <= 8'd0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            count_q  <= count_d;
            level_q  <= level_d;
            pulse_q  <= pulse_d;
            busy_q   <= busy_d;
            glitch_q <= glitch_d;
        end
    end

    assign level      = level_q;
    assign pulse      = pulse_q;
    assign busy       = busy_q;
    assign glitch_cnt = glitch_q;

endmodule
